// File: rtl/switch_alloc_if.sv
// switch_alloc_if: input-buffer, allocator, credit and crossbar signals of one router's switch allocator.
// master = environment side (buffers, allocator, downstream), slave = controller side.
interface switch_alloc_if #(
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0]                in_valid;
    logic [NUM_PORTS-1:0]                in_head;
    logic [NUM_PORTS-1:0]                in_tail;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] in_dest;
    logic [NUM_PORTS-1:0]                in_ready;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] alloc_req;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] alloc_grant;
    logic [NUM_PORTS-1:0]                credit_ret;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] xbar_sel;
    logic [NUM_PORTS-1:0]                xbar_valid;

    modport master (
        output in_valid, in_head, in_tail, in_dest, alloc_grant, credit_ret,
        input  in_ready, alloc_req, xbar_sel, xbar_valid
    );
    modport slave (
        input  in_valid, in_head, in_tail, in_dest, alloc_grant, credit_ret,
        output in_ready, alloc_req, xbar_sel, xbar_valid
    );
endinterface

// File: rtl/switch_alloc_ctrl.sv
// switch_alloc_ctrl: per-input packet locks, per-output credits and crossbar select around an external allocator.
// Define SWITCH_ALLOC_CREDIT_BYPASS_EN to let a same-cycle credit return count toward eligibility.
module switch_alloc_ctrl #(
    parameter int NUM_PORTS = 4,
    parameter int BUF_DEPTH = 4,
    parameter int CREDIT_W  = $clog2(BUF_DEPTH + 1)
) (
    input logic           clk,
    input logic           reset,
    switch_alloc_if.slave bus_io
);
    localparam int N = NUM_PORTS;
    localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(BUF_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e                      state_q [N];
    state_e                      state_d [N];
    logic [N-1:0][N-1:0]         lock_q, lock_d;
    logic [N-1:0]                busy_q, busy_d;
    logic [N-1:0][CREDIT_W-1:0]  credit_q, credit_d;
    logic [N-1:0][N-1:0]         sel_q, sel_d;
    logic [N-1:0]                cred_ok, xfer, xv, tail_o, col_used;
    logic [N-1:0][N-1:0]         req, cur_sel, xsel, acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) state_q[i] <= IDLE;
            lock_q   <= '0;
            busy_q   <= '0;
            credit_q <= {N{FULL}};
            sel_q    <= '0;
        end else begin
            for (int i = 0; i < N; i++) state_q[i] <= state_d[i];
            lock_q   <= lock_d;
            busy_q   <= busy_d;
            credit_q <= credit_d;
            sel_q    <= sel_d;
        end
    end

    // Grant acceptance lives here so the request path never depends on the grant.
    always_comb begin
        acc      = '0;
        col_used = '0;
        for (int o = 0; o < N; o++)
            for (int i = 0; i < N; i++)
                if (bus_io.alloc_grant[o][i] && req[i][o] && !(|acc[o]) && !col_used[i]) begin
                    acc[o][i]   = 1'b1;
                    col_used[i] = 1'b1;
                end
        lock_d = lock_q;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            if (state_q[i] == ACTIVE && xfer[i] && bus_io.in_tail[i]) state_d[i] = IDLE;
            else if (state_q[i] == IDLE && col_used[i]) begin
                state_d[i] = ACTIVE;
                for (int o = 0; o < N; o++) lock_d[i][o] = acc[o][i];
            end
        end
        for (int o = 0; o < N; o++) begin
            busy_d[o]   = (busy_q[o] & ~(xv[o] & tail_o[o])) | (|acc[o]);
            credit_d[o] = (xv[o] && !bus_io.credit_ret[o]) ? credit_q[o] - 1'b1 :
                          (!xv[o] && bus_io.credit_ret[o] && credit_q[o] != FULL) ? credit_q[o] + 1'b1 :
                          credit_q[o];
        end
        sel_d = xsel;
    end

    always_comb begin
        cred_ok = '0;
        req     = '0;
        xfer    = '0;
        cur_sel = '0;
        xv      = '0;
        tail_o  = '0;
        xsel    = '0;
        for (int o = 0; o < N; o++)
`ifdef SWITCH_ALLOC_CREDIT_BYPASS_EN
            cred_ok[o] = (credit_q[o] != '0) | bus_io.credit_ret[o];
`else
            cred_ok[o] = credit_q[o] != '0;
`endif
        for (int i = 0; i < N; i++) begin
            for (int o = 0; o < N; o++)
                req[i][o] = reset & (state_q[i] == IDLE) & bus_io.in_valid[i] & bus_io.in_head[i] &
                            bus_io.in_dest[i][o] & ~busy_q[o] & cred_ok[o];
            xfer[i] = (state_q[i] == ACTIVE) & bus_io.in_valid[i] & (|(lock_q[i] & cred_ok));
        end
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) cur_sel[o][i] = xfer[i] & lock_q[i][o];
            xv[o]     = |cur_sel[o];
            tail_o[o] = |(cur_sel[o] & bus_io.in_tail);
            xsel[o]   = xv[o] ? cur_sel[o] : sel_q[o];
        end
    end

    assign bus_io.alloc_req  = req;
    assign bus_io.in_ready   = xfer;
    assign bus_io.xbar_valid = xv;
    assign bus_io.xbar_sel   = xsel;
endmodule

// File: tb/tb_switch_alloc_ctrl.sv
// tb_switch_alloc_ctrl: directed scenarios plus randomized traffic against a packet-level reference model.
module tb_switch_alloc_ctrl;
    localparam int N  = 4;
    localparam int BD = 4;
    localparam int W  = 2 * N * N + 2 * N;
`ifdef SWITCH_ALLOC_CREDIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    switch_alloc_if #(.NUM_PORTS(N)) bus();
    switch_alloc_ctrl #(.NUM_PORTS(N), .BUF_DEPTH(BD)) dut (.clk(clk), .reset(rst_n), .bus_io(bus.slave));

    // Allocator stand-in: grants (a masked subset of) real requests plus arbitrary junk bits.
    logic gauto = 1'b0;
    logic [N-1:0][N-1:0] gmask = '0, gjunk = '0;
    always_comb
        for (int o = 0; o < N; o++)
            for (int i = 0; i < N; i++)
                bus.alloc_grant[o][i] = (gauto & bus.alloc_req[i][o] & gmask[o][i]) | gjunk[o][i];

    int nchk = 0, nerr = 0;
    int len [N], pos [N], dst [N];
    logic [N-1:0] vm, ret_v;
    int lock [N], cred [N];
    logic [N-1:0] hold [N];
    logic [N-1:0][N-1:0] e_req, e_sel, acc;
    logic [N-1:0] e_rdy, e_xv, e_ret, e_tail;

    function automatic logic [W-1:0] obs();
        return {bus.alloc_req, bus.in_ready, bus.xbar_valid, bus.xbar_sel};
    endfunction

    function automatic logic [W-1:0] expv();
        return {e_req, e_rdy, e_xv, e_sel};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            lock[k] = -1;
            cred[k] = BD;
            hold[k] = '0;
        end
    endtask

    task automatic src_clear();
        for (int k = 0; k < N; k++) begin
            len[k] = 0;
            pos[k] = 0;
            dst[k] = 0;
        end
        vm = '1;
        ret_v = '0;
        gauto = 1'b1;
        gmask = '1;
        gjunk = '0;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            bus.in_valid[k] = (pos[k] < len[k]) && vm[k];
            bus.in_head[k]  = pos[k] == 0;
            bus.in_tail[k]  = pos[k] == len[k] - 1;
            bus.in_dest[k]  = N'(1 << dst[k]);
        end
        bus.credit_ret = ret_v;
    endtask

    task automatic eval();
        bit busy [N];
        bit ok [N];
        bit done;
        for (int o = 0; o < N; o++) begin
            busy[o] = 1'b0;
            for (int i = 0; i < N; i++) if (lock[i] == o) busy[o] = 1'b1;
            ok[o] = cred[o] > 0 || (BYP && bus.credit_ret[o]);
        end
        e_req = '0;
        for (int i = 0; i < N; i++)
            for (int o = 0; o < N; o++)
                e_req[i][o] = rst_n && lock[i] < 0 && bus.in_valid[i] && bus.in_head[i] &&
                              bus.in_dest[i][o] && !busy[o] && ok[o];
        acc = '0;
        for (int o = 0; o < N; o++) begin
            done = 1'b0;
            for (int i = 0; i < N; i++)
                if (!done && e_req[i][o] && bus.alloc_grant[o][i]) begin
                    acc[o][i] = 1'b1;
                    done = 1'b1;
                end
        end
        e_rdy = '0;
        e_xv = '0;
        for (int o = 0; o < N; o++) e_sel[o] = hold[o];
        for (int i = 0; i < N; i++)
            if (lock[i] >= 0 && bus.in_valid[i] && ok[lock[i]]) begin
                e_rdy[i] = 1'b1;
                e_xv[lock[i]] = 1'b1;
                e_sel[lock[i]] = N'(1 << i);
            end
        e_ret = bus.credit_ret;
        e_tail = bus.in_tail;
    endtask

    task automatic update();
        for (int o = 0; o < N; o++) begin
            cred[o] = cred[o] - int'(e_xv[o]) + int'(e_ret[o]);
            if (cred[o] > BD) cred[o] = BD;
            hold[o] = e_sel[o];
        end
        for (int i = 0; i < N; i++)
            if (e_rdy[i]) begin
                pos[i]++;
                if (e_tail[i]) lock[i] = -1;
            end
        for (int o = 0; o < N; o++)
            for (int i = 0; i < N; i++)
                if (acc[o][i]) lock[i] = o;
    endtask

    task automatic pre();
        drive();
        @(negedge clk);
        eval();
    endtask

    task automatic post();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_clear();
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        src_clear();
        for (int k = 0; k < N; k++) len[k] = 2;
        gjunk = '1;
        drive();
        @(negedge clk);
        nchk++;
        if (obs() !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got %h exp 0", obs());
        end
        do_reset();
        pre();
        nchk++;
        if (obs() !== expv()) begin
            nerr++;
            $display("FAIL reset_idle: got %h exp %h", obs(), expv());
        end
        post();
    endtask

    task automatic test_lock_release();
        do_reset();
        len[0] = 4; dst[0] = 2;
        len[1] = 1; dst[1] = 2;
        for (int c = 0; c < 8; c++) begin
            ret_v = (c == 1) ? 4'b0100 : 4'b0000;
            pre();
            nchk++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL lock_model c%0d: got %h exp %h", c, obs(), expv());
            end
            if (c == 0) begin
                nchk++;
                if ({bus.alloc_req[0][2], bus.alloc_req[1][2], bus.in_ready} !== 6'b11_0000) begin
                    nerr++;
                    $display("FAIL first_req: got %b exp 110000", {bus.alloc_req[0][2], bus.alloc_req[1][2], bus.in_ready});
                end
            end
            if (c == 1) begin
                nchk++;
                if ({bus.in_ready[0], bus.xbar_valid[2], bus.xbar_sel[2], bus.alloc_req[1][2]} !== 7'b1_1_0001_0) begin
                    nerr++;
                    $display("FAIL first_xfer: got %b exp 1100010", {bus.in_ready[0], bus.xbar_valid[2], bus.xbar_sel[2], bus.alloc_req[1][2]});
                end
            end
            if (c == 4) begin
                nchk++;
                if ({bus.in_ready[0], bus.alloc_req[1][2]} !== 2'b10) begin
                    nerr++;
                    $display("FAIL tail_xfer: got %b exp 10", {bus.in_ready[0], bus.alloc_req[1][2]});
                end
            end
            if (c == 5) begin
                nchk++;
                if ({bus.alloc_req[1][2], bus.in_ready[1]} !== 2'b10) begin
                    nerr++;
                    $display("FAIL rereq_after_tail: got %b exp 10", {bus.alloc_req[1][2], bus.in_ready[1]});
                end
            end
            if (c == 6) begin
                nchk++;
                if ({bus.in_ready[1], bus.xbar_sel[2]} !== 5'b1_0010) begin
                    nerr++;
                    $display("FAIL second_xfer: got %b exp 10010", {bus.in_ready[1], bus.xbar_sel[2]});
                end
            end
            post();
        end
    endtask

    task automatic test_credit_stall();
        do_reset();
        len[0] = 6; dst[0] = 1;
        for (int c = 0; c < 10; c++) begin
            ret_v = (c == 7) ? 4'b0010 : 4'b0000;
            pre();
            nchk++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL stall_model c%0d: got %h exp %h", c, obs(), expv());
            end
            if (c == 5 || c == 7 || c == 8) begin
                nchk++;
                if (bus.in_ready[0] !== ((c == 7) ? BYP : (c == 8) ? !BYP : 1'b0)) begin
                    nerr++;
                    $display("FAIL stall_ready c%0d: got %b exp %b", c, bus.in_ready[0], (c == 7) ? BYP : (c == 8) ? !BYP : 1'b0);
                end
            end
            post();
        end
    endtask

    task automatic test_credit_sat();
        do_reset();
        len[0] = 6; dst[0] = 3;
        for (int c = 0; c < 8; c++) begin
            ret_v = (c == 0 || c == 3) ? 4'b1000 : 4'b0000;
            pre();
            nchk++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL sat_model c%0d: got %h exp %h", c, obs(), expv());
            end
            if (c == 5 || c == 6) begin
                nchk++;
                if (bus.in_ready[0] !== (c == 5)) begin
                    nerr++;
                    $display("FAIL sat_ready c%0d: got %b exp %b", c, bus.in_ready[0], c == 5);
                end
            end
            post();
        end
    endtask

    task automatic test_bad_grant();
        do_reset();
        gauto = 1'b0;
        gjunk[1][3] = 1'b1;
        len[3] = 1; dst[3] = 2;
        len[2] = 3; pos[2] = 1; dst[2] = 0;
        for (int c = 0; c < 3; c++) begin
            pre();
            nchk++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL badgnt_model c%0d: got %h exp %h", c, obs(), expv());
            end
            nchk++;
            if ({bus.in_ready, bus.alloc_req[3], bus.alloc_req[2]} !== 12'b0000_0100_0000) begin
                nerr++;
                $display("FAIL badgnt c%0d: got %b exp 000001000000", c, {bus.in_ready, bus.alloc_req[3], bus.alloc_req[2]});
            end
            post();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        len[2] = 8; dst[2] = 0;
        for (int c = 0; c < 5; c++) begin
            pre();
            nchk++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL mid_model c%0d: got %h exp %h", c, obs(), expv());
            end
            if (c < 4) post();
        end
        rst_n = 1'b0;
        #1;
        nchk++;
        if (obs() !== '0) begin
            nerr++;
            $display("FAIL async_reset: got %h exp 0", obs());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        len[2] = 8; pos[2] = 1; dst[2] = 0;
        for (int c = 0; c < 2; c++) begin
            pre();
            nchk++;
            if ({bus.alloc_req[2], bus.in_ready} !== 8'h00 || obs() !== expv()) begin
                nerr++;
                $display("FAIL body_after_reset c%0d: got %h exp %h", c, obs(), expv());
            end
            post();
        end
        len[2] = 6; pos[2] = 0;
        for (int c = 0; c < 7; c++) begin
            pre();
            nchk++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL rereq_model c%0d: got %h exp %h", c, obs(), expv());
            end
            if (c == 4 || c == 5) begin
                nchk++;
                if (bus.in_ready[2] !== (c == 4)) begin
                    nerr++;
                    $display("FAIL credit_restored c%0d: got %b exp %b", c, bus.in_ready[2], c == 4);
                end
            end
            post();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++)
                if (pos[k] >= len[k]) begin
                    len[k] = $urandom_range(1, 5);
                    pos[k] = 0;
                    dst[k] = $urandom_range(0, N - 1);
                end
            vm    = N'($urandom | $urandom);
            ret_v = N'($urandom & $urandom & $urandom);
            gmask = (N * N)'($urandom);
            gjunk = (N * N)'($urandom & $urandom & $urandom);
            pre();
            nchk++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL random c%0d: got %h exp %h", c, obs(), expv());
            end
            post();
        end
    endtask

    initial begin
        test_reset();
        test_lock_release();
        test_credit_stall();
        test_credit_sat();
        test_bad_grant();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/switch_alloc_ctrl.md
Name: switch_alloc_ctrl

Overview:
- Switch-allocation controller for one router.
- Takes head/body/tail flit requests from NUM_PORTS input ports, builds the request matrix for the external square matrix allocator, and registers the allocator's grants as packet-long input→output locks.
- Tracks downstream credits for each output and drives the crossbar select for each output.
- Sits between the input buffers and the crossbar, wrapping the allocator combinationally: request out, grant in, same cycle.

Parameters:
- NUM_PORTS, 4, number of input ports and number of output ports (square).
- BUF_DEPTH, 4, downstream buffer depth per output; credit counter reset value.
- CREDIT_W, $clog2(BUF_DEPTH+1), width of each credit counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in_valid  input  NUM_PORTS  flit present at the head of input i's buffer.
- in_head  input  NUM_PORTS  flit at input i is a head flit.
- in_tail  input  NUM_PORTS  flit at input i is a tail flit; head and tail may both be set (single-flit packet).
- in_dest  input  NUM_PORTS x NUM_PORTS  in_dest[i] = one-hot output port of input i's head flit; ignored unless in_head[i].
- in_ready  output  NUM_PORTS  flit at input i is dequeued this cycle.
- alloc_req  output  NUM_PORTS x NUM_PORTS  alloc_req[i][o] = input i requests output o.
- alloc_grant  input  NUM_PORTS x NUM_PORTS  alloc_grant[o][i] = output o granted to input i, combinational from the allocator.
- credit_ret  input  NUM_PORTS  one credit returned from downstream for output o.
- xbar_sel  output  NUM_PORTS x NUM_PORTS  xbar_sel[o] = one-hot input driving output o.
- xbar_valid  output  NUM_PORTS  output o carries a valid flit this cycle.

Behaviour:
- Each input has a 2-state FSM, IDLE / ACTIVE, plus a registered locked-output one-hot lock_out[i].
- Each output has a busy bit and a credit counter credit[o].
- alloc_req[i][o] = IDLE[i] & in_valid[i] & in_head[i] & in_dest[i][o] & ~busy[o] & (credit[o] != 0).
- Grant acceptance:
  - alloc_grant[o][i] is honoured only where alloc_req[i][o] = 1; all other grant bits are ignored.
  - If more than one honoured bit falls in a row or column, the lowest index wins.
- Honoured grant at cycle N: at the edge ending N, input i goes to ACTIVE, lock_out[i] = o, busy[o] = 1.
- No flit moves in the grant cycle. First transfer is at earliest cycle N+1.
- Transfer on input i in ACTIVE, cycle M:
  - Condition: in_valid[i] & (credit[lock_out[i]] != 0).
  - Effects in cycle M: in_ready[i] = 1, xbar_valid[o] = 1, xbar_sel[o] = one-hot(i).
  - Otherwise in_ready[i] = 0 and xbar_valid[o] = 0; xbar_sel holds its last value.
- Tail transfer at cycle M: input returns to IDLE and busy[o] clears at the edge ending M. Output o is requestable again from cycle M+1.
- Head/tail single flit: one ACTIVE cycle, then IDLE.
- in_ready is never asserted in IDLE. A non-head flit seen in IDLE is left untouched (no ready, no request).
- A head flit seen in ACTIVE is treated as a body flit (transferred); in_head is ignored in ACTIVE.
- Credits:
  - Transfer decrements credit[o]; credit_ret[o] increments it.
  - Both in the same cycle: counter unchanged.
  - credit_ret when credit[o] == BUF_DEPTH: counter saturates (no change).
  - Counter can never go below 0, because transfer is gated on a nonzero count.
- Reset (asynchronous assert, at any time including mid-packet):
  - All FSMs IDLE, busy = 0, lock_out = 0, credit = BUF_DEPTH.
  - xbar_sel = 0, xbar_valid = 0, in_ready = 0, alloc_req = 0.
  - Locks in flight are dropped; no partial flit state survives.
- Latency: head flit valid at cycle N with a free output and a grant gives head transferred at cycle N+1. Body flits then move 1 per cycle while credits allow.

Optional Feature:
- Macro: SWITCH_ALLOC_CREDIT_BYPASS_EN.
- Defined: credit_ret[o] in cycle M counts toward eligibility in cycle M. Both the alloc_req gate and the transfer gate use (credit[o] + credit_ret[o]) != 0, so a zero counter with a return this cycle allows a transfer; the counter stays 0.
- Not defined: only the registered credit[o] is used, so a return becomes usable in cycle M+1.

Test Plan (NUM_PORTS=4, BUF_DEPTH=4):
- After reset, input 0 presents head to output 2 at cycle 0, grant[2][0] = 1 -> alloc_req[0][2] = 1 at cycle 0; in_ready[0] = 1, xbar_sel[2] = 4'b0001, xbar_valid[2] = 1 at cycle 1; credit[2] = 3 afterwards.
- 4-flit packet 0→2, then input 1 head to output 2 -> alloc_req[1][2] = 0 until the cycle after input 0's tail transfer; the 1→2 transfer starts 2 cycles after that tail.
- 6-flit packet 0→1, no credit_ret -> 4 transfers, then in_ready[0] = 0; credit_ret[1] pulse at cycle K -> transfer at K+1 (macro off) or K (macro on).
- Transfer and credit_ret on output 3 in the same cycle with credit[3] = 2 -> credit[3] stays 2; credit_ret with credit[3] = 4 -> stays 4.
- Grant for a non-requested pair (grant[1][3] = 1, alloc_req[3][1] = 0) -> no state change, in_ready = 0.
- reset driven low mid-packet (input 2 ACTIVE to output 0, credit[0] = 1) -> immediately all outputs 0, credit[0] = 4 after release, input 2 must present a head to re-request.
